// File: rtl/ram_dump_arbiter_pkg.sv
// Shared types and constants for the RAM dump arbiter: FSM state encoding,
// default geometry and the number of bytes serialised per 32-bit word.
package ram_dump_arbiter_pkg;

  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_AW     = 5;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

endpackage

// File: rtl/ram_dump_arbiter_byte_serializer.sv
// Byte serializer: captures one RAM word and presents it LSB byte first on a
// valid/ready stream, flagging the handshake of the final byte.
module byte_serializer
  import ram_dump_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        active_i,
  input  logic        byte_ready_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_out_o,
  output logic        byte_valid_o,
  output logic        last_xfer_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic        xfer_s;

  assign xfer_s = active_i & byte_ready_i;

  // Next shift-register contents and byte index
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = 2'd0;
    end else if (xfer_s) begin
      shift_d = {8'h00, shift_q[31:8]};
      idx_d   = idx_q + 2'd1;
    end else begin
      shift_d = shift_q;
      idx_d   = idx_q;
    end
  end

  // Shift register and index state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 32'h0000_0000;
      idx_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // The low byte always holds word[8*idx+7:8*idx] because each transfer shifts right by 8
  assign byte_valid_o = active_i;
  assign byte_out_o   = active_i ? shift_q[7:0] : 8'h00;
  assign last_xfer_o  = xfer_s && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ram_dump_arbiter.sv
// Shares a single-port RAM between a CPU (absolute priority) and a dump engine
// that streams a range of words out as bytes over a valid/ready interface.
module ram_dump_arbiter
  import ram_dump_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          dump_start,
  input  logic [AW-1:0] dump_base,
  input  logic [AW:0]   dump_count,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          dump_busy,
  output logic          dump_done
);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          last_xfer_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          state_d = (dump_count == {(AW+1){1'b0}}) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE:   state_d = cpu_req ? ST_ISSUE : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (last_xfer_s) begin
          state_d = (rem_q == (AW+1)'(1)) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and remaining-word bookkeeping
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if ((state_q == ST_IDLE) && dump_start) begin
      addr_d = dump_base;
      rem_d  = dump_count;
    end else if ((state_q == ST_SHIFT) && last_xfer_s) begin
      rem_d  = rem_q - (AW+1)'(1);
      addr_d = (addr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : addr_q + AW'(1);
    end else begin
      addr_d = addr_q;
      rem_d  = rem_q;
    end
  end

  // Address and remaining-word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= {AW{1'b0}};
      rem_q  <= {(AW+1){1'b0}};
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  // RAM port mux and status outputs; stays combinational through reset so the CPU keeps access
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {AW{1'b0}};
    ram_wdata = 32'h0000_0000;
    if (cpu_req) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (state_q == ST_ISSUE) begin
      ram_we    = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = 32'h0000_0000;
    end else begin
      ram_we    = 1'b0;
      ram_addr  = {AW{1'b0}};
      ram_wdata = 32'h0000_0000;
    end
    dump_busy = (state_q != ST_IDLE);
    dump_done = (state_q == ST_DONE);
  end

  assign cpu_rdata = ram_rdata;

  byte_serializer u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (state_q == ST_CAPTURE),
    .active_i     (state_q == ST_SHIFT),
    .byte_ready_i (byte_ready),
    .word_i       (ram_rdata),
    .byte_out_o   (byte_out),
    .byte_valid_o (byte_valid),
    .last_xfer_o  (last_xfer_s)
  );

endmodule

// File: tb/tb_ram_dump_arbiter.sv
// Self-checking bench for ram_dump_arbiter: behavioural RAM, byte scoreboard,
// table of dump scenarios plus a hand-written mid-dump reset sequence.
module tb_ram_dump_arbiter;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0, cpu_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          dump_start = 1'b0;
  logic [AW-1:0] dump_base = '0;
  logic [AW:0]   dump_count = '0;
  logic [7:0]    byte_out;
  logic          byte_valid, byte_ready = 1'b1;
  logic          dump_busy, dump_done;

  always #5 clk = ~clk;

  ram_dump_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dump_start(dump_start), .dump_base(dump_base), .dump_count(dump_count),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  // Synchronous single-port RAM, 1-cycle read latency
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = rdata_q;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid byte must match the queue head; a handshake pops it
  always @(negedge clk) begin
    if (dump_done) done_cnt++;
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", 32'(byte_out), 32'h0000_0100);
      end else begin
        check("byte_data", 32'(byte_out), 32'(exp_q[0]));
        if (byte_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check(name, cpu_rdata, exp);
  endtask

  // One dump with optional CPU stall in ISSUE, ready stall on a byte, and a stray start
  task automatic run_dump(input logic [AW-1:0] b, input logic [AW:0] c, input int issue_stall,
                          input int rdy_byte, input int rdy_len, input int bogus, input string name);
    int cyc, xfers, left, exp_cyc, done0;
    bit done_seen;
    exp_cyc = 6 * int'(c) + 1 + issue_stall + rdy_len;
    done0 = done_cnt; cyc = 0; xfers = 0; left = rdy_len; done_seen = 1'b0;
    dump_start = 1'b1; dump_base = b; dump_count = c;
    while (!done_seen && cyc < 2000) begin
      @(posedge clk); cyc++; #1;
      dump_start = (bogus > 0) && (cyc == bogus);
      dump_base  = 5'd0;
      dump_count = 6'd1;
      cpu_req    = (cyc <= issue_stall);
      cpu_we     = cpu_req;
      byte_ready = !((xfers == rdy_byte) && (left > 0));
      @(negedge clk);
      if (cyc == 1) check({name, "_busy"}, 32'(dump_busy), 32'd1);
      if (byte_valid && !byte_ready) left--;
      if (byte_valid && byte_ready) xfers++;
      if (dump_done) done_seen = 1'b1;
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    @(posedge clk); #1;
    dump_start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; byte_ready = 1'b1;
    check({name, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle_busy"}, 32'(dump_busy), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic [31:0]   w0, w1;
    int            issue_stall, rdy_byte, rdy_len, bogus;
    logic [AW-1:0] cw_addr;
    logic [31:0]   cw_data;
  } vec_t;

  vec_t vec [6];

  initial begin
    int xfers, cyc, done0;
    vec[0] = '{5'd3,  6'd1, 32'hDDCC_BBAA, 32'h0000_0000, 0,  -1, 0, 0, 5'd0,  32'h0};
    vec[1] = '{5'd31, 6'd2, 32'h1111_1111, 32'h2222_2222, 0,  -1, 0, 0, 5'd0,  32'h0};
    vec[2] = '{5'd5,  6'd1, 32'h1234_5678, 32'h0000_0000, 3,  -1, 0, 0, 5'd10, 32'hCAFE_F00D};
    vec[3] = '{5'd0,  6'd1, 32'hDDCC_BBAA, 32'h9999_9999, 0,   2, 5, 0, 5'd0,  32'h0};
    vec[4] = '{5'd7,  6'd0, 32'hEEEE_EEEE, 32'hFFFF_FFFF, 0,  -1, 0, 0, 5'd0,  32'h0};
    vec[5] = '{5'd12, 6'd2, 32'hA5A5_0F0F, 32'h8001_7FFE, 0,  -1, 0, 3, 5'd0,  32'h0};

    #2;
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      cpu_write(vec[i].base, vec[i].w0);
      cpu_write(vec[i].base + 5'd1, vec[i].w1);
      if (vec[i].count >= 6'd1) push_word(vec[i].w0);
      if (vec[i].count >= 6'd2) push_word(vec[i].w1);
      cpu_addr = vec[i].cw_addr; cpu_wdata = vec[i].cw_data;
      run_dump(vec[i].base, vec[i].count, vec[i].issue_stall, vec[i].rdy_byte,
               vec[i].rdy_len, vec[i].bogus, $sformatf("vec%0d", i));
      if (vec[i].issue_stall > 0) cpu_read(vec[i].cw_addr, vec[i].cw_data, "cpu_write_in_issue");
    end

    // Reset in SHIFT of word 2 of a 4-word dump
    for (int k = 0; k < 4; k++) cpu_write(5'd8 + 5'(k), 32'h0101_0101 * (k + 1));
    for (int k = 0; k < 4; k++) push_word(32'h0101_0101 * (k + 1));
    dump_start = 1'b1; dump_base = 5'd8; dump_count = 6'd4;
    xfers = 0; cyc = 0;
    while (xfers < 5 && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      dump_start = 1'b0;
      @(negedge clk);
      if (byte_valid && byte_ready) xfers++;
    end
    check("reset_reach_word2", 32'(xfers), 32'd5);
    done0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_byte_out", 32'(byte_out), 32'd0);
    check("midrst_byte_valid", 32'(byte_valid), 32'd0);
    check("midrst_busy", 32'(dump_busy), 32'd0);
    check("midrst_done", 32'(dump_done), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    cpu_write(5'd20, 32'h5A5A_1234);
    cpu_read(5'd20, 32'h5A5A_1234, "cpu_path_in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(dump_busy), 32'd0);
    check("no_done_on_abort", 32'(done_cnt - done0), 32'd0);
    push_word(32'h5A5A_1234);
    run_dump(5'd20, 6'd1, 0, -1, 0, 0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
